// File: rtl/inst_enc_if.sv
// Record-in / word-out handshake bundle for the MIPS instruction encoder.
// The slave side is the encoder; the master side feeds records and drains words.
interface inst_enc_if #(
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       inst;
    logic [1:0]       inst_type;
    logic [4:0]       reg_s;
    logic [4:0]       reg_t;
    logic [4:0]       reg_d;
    logic [15:0]      immediate;
    logic [4:0]       shift;
    logic [25:0]      jump_addr;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      inst_code;
    logic             out_err;
    logic [CNT_W-1:0] enc_count;
    logic [7:0]       err_count;

    modport master (
        output in_valid, inst, inst_type, reg_s, reg_t, reg_d, immediate, shift, jump_addr,
        output out_ready,
        input  in_ready, out_valid, inst_code, out_err, enc_count, err_count
    );

    modport slave (
        input  in_valid, inst, inst_type, reg_s, reg_t, reg_d, immediate, shift, jump_addr,
        input  out_ready,
        output in_ready, out_valid, inst_code, out_err, enc_count, err_count
    );
endinterface

// File: rtl/inst_enc.sv
// Re-encodes decoded MIPS records into 32-bit instruction words.
// One register stage feeds a small FIFO; unencodable records emit a zero word flagged err.
module inst_enc #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input logic          clk,
    input logic          rst_n,
    inst_enc_if.slave    bus
);
    // Inst mark and inst type codes, matching defs.v
    localparam logic [7:0] INST_SLL   = 8'h01, INST_SRL   = 8'h02, INST_SRA   = 8'h03;
    localparam logic [7:0] INST_JR    = 8'h04, INST_ADDU  = 8'h05, INST_SUBU  = 8'h06;
    localparam logic [7:0] INST_AND   = 8'h07, INST_OR    = 8'h08, INST_XOR   = 8'h09;
    localparam logic [7:0] INST_NOR   = 8'h0A, INST_SLT   = 8'h0B, INST_SLTU  = 8'h0C;
    localparam logic [7:0] INST_BEQ   = 8'h0D, INST_BNE   = 8'h0E, INST_ADDIU = 8'h0F;
    localparam logic [7:0] INST_SLTI  = 8'h10, INST_ANDI  = 8'h11, INST_ORI   = 8'h12;
    localparam logic [7:0] INST_XORI  = 8'h13, INST_LUI   = 8'h14, INST_LW    = 8'h15;
    localparam logic [7:0] INST_SW    = 8'h16, INST_J     = 8'h17, INST_JAL   = 8'h18;
    localparam logic [1:0] INST_TYPE_INVALID = 2'd0, INST_TYPE_R = 2'd1;
    localparam logic [1:0] INST_TYPE_I = 2'd2, INST_TYPE_J = 2'd3;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W+1:0] DEPTH_W = DEPTH[PTR_W+1:0];

    typedef struct packed {
        logic [7:0]  inst;
        logic [1:0]  inst_type;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [4:0]  shamt;
        logic [25:0] jaddr;
    } rec_t;

    rec_t             rec_d, rec_q;
    logic             s1_valid_d, s1_valid_q;
    logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
    logic [PTR_W:0]   count_d, count_q;
    logic [CNT_W-1:0] enc_count_d, enc_count_q;
    logic [7:0]       err_count_d, err_count_q;
    logic [32:0]      mem_d [DEPTH];
    logic [32:0]      mem_q [DEPTH];

    logic [PTR_W+1:0] used;
    logic             accept, push, pop;
    logic [31:0]      enc_word;
    logic             enc_err;
    logic [5:0]       funct, opcode;
    logic [4:0]       rs_f, rt_f, rd_f, sh_f;

    // s1 counts as occupied so its word always has a slot waiting
    assign used         = {1'b0, count_q} + {{(PTR_W + 1){1'b0}}, s1_valid_q};
    assign bus.in_ready = rst_n && (used < DEPTH_W);
    assign accept       = bus.in_valid && bus.in_ready;
    assign push         = s1_valid_q;
    assign bus.out_valid = (count_q != '0);
    assign pop          = bus.out_valid && bus.out_ready;
    assign bus.inst_code = bus.out_valid ? mem_q[rd_ptr_q][31:0] : 32'h0;
    assign bus.out_err   = bus.out_valid ? mem_q[rd_ptr_q][32] : 1'b0;
    assign bus.enc_count = enc_count_q;
    assign bus.err_count = err_count_q;

    always_comb begin
        enc_word = 32'h0;
        enc_err  = 1'b0;
        funct    = 6'h00;
        opcode   = 6'h00;
        rs_f     = rec_q.rs;
        rt_f     = rec_q.rt;
        rd_f     = rec_q.rd;
        sh_f     = 5'd0;
        case (rec_q.inst_type)
            INST_TYPE_R: begin
                case (rec_q.inst)
                    INST_SLL:  funct = 6'h00;
                    INST_SRL:  funct = 6'h02;
                    INST_SRA:  funct = 6'h03;
                    INST_JR:   funct = 6'h08;
                    INST_ADDU: funct = 6'h21;
                    INST_SUBU: funct = 6'h23;
                    INST_AND:  funct = 6'h24;
                    INST_OR:   funct = 6'h25;
                    INST_XOR:  funct = 6'h26;
                    INST_NOR:  funct = 6'h27;
                    INST_SLT:  funct = 6'h2A;
                    INST_SLTU: funct = 6'h2B;
                    default:   enc_err = 1'b1;
                endcase
                if (rec_q.inst == INST_SLL || rec_q.inst == INST_SRL || rec_q.inst == INST_SRA) begin
                    sh_f = rec_q.shamt;
                end
                if (rec_q.inst == INST_JR) begin
                    rt_f = 5'd0;
                    rd_f = 5'd0;
                end
                enc_word = {6'h00, rs_f, rt_f, rd_f, sh_f, funct};
            end
            INST_TYPE_I: begin
                case (rec_q.inst)
                    INST_BEQ:   opcode = 6'h04;
                    INST_BNE:   opcode = 6'h05;
                    INST_ADDIU: opcode = 6'h09;
                    INST_SLTI:  opcode = 6'h0A;
                    INST_ANDI:  opcode = 6'h0C;
                    INST_ORI:   opcode = 6'h0D;
                    INST_XORI:  opcode = 6'h0E;
                    INST_LUI:   opcode = 6'h0F;
                    INST_LW:    opcode = 6'h23;
                    INST_SW:    opcode = 6'h2B;
                    default:    enc_err = 1'b1;
                endcase
                if (rec_q.inst == INST_LUI) begin
                    rs_f = 5'd0;
                end
                enc_word = {opcode, rs_f, rt_f, rec_q.imm};
            end
            INST_TYPE_J: begin
                case (rec_q.inst)
                    INST_J:   opcode = 6'h02;
                    INST_JAL: opcode = 6'h03;
                    default:  enc_err = 1'b1;
                endcase
                enc_word = {opcode, rec_q.jaddr};
            end
            default: enc_err = 1'b1;
        endcase
        if (enc_err) begin
            enc_word = 32'h0;
        end
    end

    always_comb begin
        rec_d       = rec_q;
        s1_valid_d  = accept;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        enc_count_d = enc_count_q;
        err_count_d = err_count_q;
        mem_d       = mem_q;
        if (accept) begin
            rec_d = '{inst: bus.inst, inst_type: bus.inst_type, rs: bus.reg_s, rt: bus.reg_t,
                      rd: bus.reg_d, imm: bus.immediate, shamt: bus.shift,
                      jaddr: bus.jump_addr};
        end
        if (push) begin
            mem_d[wr_ptr_q] = {enc_err, enc_word};
            wr_ptr_d        = wr_ptr_q + 1'b1;
            enc_count_d     = enc_count_q + 1'b1;
            if (enc_err && err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            enc_count_q <= '0;
            err_count_q <= 8'h00;
        end else begin
            s1_valid_q  <= s1_valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            enc_count_q <= enc_count_d;
            err_count_q <= err_count_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by s1_valid_q and count_q
    always_ff @(posedge clk) begin
        rec_q <= rec_d;
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_inst_enc.sv
// Directed bench for inst_enc: encoding table, error words, backpressure fill/drain, reset flush.
module tb_inst_enc;
    localparam logic [7:0] INST_SLL = 8'h01, INST_JR = 8'h04, INST_ADDU = 8'h05;
    localparam logic [7:0] INST_SUBU = 8'h06, INST_AND = 8'h07, INST_ADDIU = 8'h0F;
    localparam logic [7:0] INST_ORI = 8'h12, INST_LUI = 8'h14, INST_JAL = 8'h18;
    localparam logic [1:0] T_INV = 2'd0, T_R = 2'd1, T_I = 2'd2, T_J = 2'd3;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;

    inst_enc_if #(.CNT_W(16)) bus ();

    inst_enc #(.DEPTH(4), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] i, input logic [1:0] t, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                         input logic [4:0] sh, input logic [25:0] ja);
        bus.inst      = i;
        bus.inst_type = t;
        bus.reg_s     = rs;
        bus.reg_t     = rt;
        bus.reg_d     = rd;
        bus.immediate = imm;
        bus.shift     = sh;
        bus.jump_addr = ja;
        bus.in_valid  = 1'b1;
    endtask

    task automatic send(input logic [7:0] i, input logic [1:0] t, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                        input logic [4:0] sh, input logic [25:0] ja);
        drive(i, t, rs, rt, rd, imm, sh, ja);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] code, input logic err);
        int n = 0;
        while (!bus.out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_code"}, bus.inst_code, code);
        chk({tag, "_err"}, 32'(bus.out_err), 32'(err));
        @(negedge clk);
    endtask

    logic [31:0] exp_q[$];
    logic [31:0] exp_w;
    int          acc;

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(8'h00, T_INV, 5'd0, 5'd0, 5'd0, 16'h0, 5'd0, 26'h0);
        bus.in_valid  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready_low", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_inst_code", bus.inst_code, 32'h0);
        chk("rst_out_err", 32'(bus.out_err), 32'd0);
        chk("rst_enc_count", 32'(bus.enc_count), 32'd0);
        chk("rst_err_count", 32'(bus.err_count), 32'd0);
        chk("rst_in_ready_high", 32'(bus.in_ready), 32'd1);
        @(negedge clk);

        // Latency: word visible one cycle after the accept edge
        bus.out_ready = 1'b1;
        send(INST_ADDU, T_R, 5'd1, 5'd2, 5'd3, 16'h0, 5'd0, 26'h0);
        chk("addu_s1_only", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("addu_enc_count", 32'(bus.enc_count), 32'd1);
        expect_word("addu", 32'h00221821, 1'b0);

        send(INST_SLL, T_R, 5'd0, 5'd2, 5'd4, 16'h0, 5'd5, 26'h0);
        expect_word("sll", 32'h00022140, 1'b0);
        send(INST_JR, T_R, 5'd31, 5'd7, 5'd7, 16'h0, 5'd3, 26'h0);
        expect_word("jr", 32'h03E00008, 1'b0);
        send(INST_ADDIU, T_I, 5'd0, 5'd8, 5'd9, 16'hFFFF, 5'd0, 26'h0);
        expect_word("addiu", 32'h2408FFFF, 1'b0);
        send(INST_LUI, T_I, 5'd5, 5'd1, 5'd0, 16'h1234, 5'd0, 26'h0);
        expect_word("lui", 32'h3C011234, 1'b0);
        send(INST_JAL, T_J, 5'd0, 5'd0, 5'd0, 16'h0, 5'd0, 26'h0100000);
        expect_word("jal", 32'h0C100000, 1'b0);

        send(INST_ADDU, T_INV, 5'd1, 5'd2, 5'd3, 16'h0, 5'd0, 26'h0);
        expect_word("err_inv_type", 32'h0, 1'b1);
        send(INST_ADDIU, T_R, 5'd1, 5'd2, 5'd3, 16'h5555, 5'd0, 26'h0);
        expect_word("err_wrong_type", 32'h0, 1'b1);
        chk("err_count_2", 32'(bus.err_count), 32'd2);
        send(INST_SUBU, T_R, 5'd4, 5'd5, 5'd6, 16'h0, 5'd0, 26'h0);
        expect_word("subu", 32'h00853023, 1'b0);
        chk("enc_count_9", 32'(bus.enc_count), 32'd9);

        // Backpressure: only DEPTH records may be taken while the consumer stalls
        bus.out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            drive(INST_ORI, T_I, 5'd0, 5'(acc), 5'd0, 16'(acc), 5'd0, 26'h0);
            if (bus.in_ready) begin
                exp_q.push_back(32'h34000000 | (32'(acc) << 16) | 32'(acc));
                acc++;
            end
            @(negedge clk);
        end
        chk("fill_accepts", 32'(acc), 32'd4);
        chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
        chk("fill_out_valid", 32'(bus.out_valid), 32'd1);

        bus.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEADBEEF;
            chk($sformatf("drain%0d_valid", c), 32'(bus.out_valid), 32'd1);
            chk($sformatf("drain%0d_code", c), bus.inst_code, exp_w);
            if (acc < 8) begin
                drive(INST_ORI, T_I, 5'd0, 5'(acc), 5'd0, 16'(acc), 5'd0, 26'h0);
                if (bus.in_ready) begin
                    exp_q.push_back(32'h34000000 | (32'(acc) << 16) | 32'(acc));
                    acc++;
                end
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("drain_accepts", 32'(acc), 32'd8);
        chk("drain_empty", 32'(bus.out_valid), 32'd0);
        chk("drain_enc_count", 32'(bus.enc_count), 32'd17);

        // Reset with three words buffered must flush everything
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send(INST_SUBU, T_R, 5'(k), 5'd1, 5'd2, 16'h0, 5'd0, 26'h0);
        end
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_enc_count", 32'(bus.enc_count), 32'd0);
        chk("flush_err_count", 32'(bus.err_count), 32'd0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("flush_stale%0d", c), 32'(bus.out_valid), 32'd0);
        end
        send(INST_AND, T_R, 5'd1, 5'd2, 5'd3, 16'h0, 5'd0, 26'h0);
        expect_word("post_rst_and", 32'h00221824, 1'b0);
        chk("post_rst_enc_count", 32'(bus.enc_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/inst_enc.md
Name: inst_enc

Overview:
- Encodes decoded MIPS instruction fields back into 32-bit instruction words: inst mark, inst type, register fields, immediate, shift and jump address.
- Used by the self-check path and the boot/program loader, which regenerate instruction memory images from decoded records.
- Has a valid/ready input, one register stage, and a small output FIFO with a valid/ready output.
- Uses the `INST_*` and `INST_TYPE_*` codes from defs.v.

Parameters:
- DEPTH, 4, number of output FIFO entries; power of two, 2..16.
- CNT_W, 16, width of the encoded-word counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- in_valid  in  1  input record valid.
- in_ready  out  1  encoder can accept a record this cycle.
- inst  in  8  inst mark (`INST_*`).
- inst_type  in  2  `INST_TYPE_R`, `INST_TYPE_I`, `INST_TYPE_J` or `INST_TYPE_INVALID`.
- reg_s  in  5  rs field.
- reg_t  in  5  rt field.
- reg_d  in  5  rd field.
- immediate  in  16  I-type immediate.
- shift  in  5  shamt field.
- jump_addr  in  26  J-type target.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes the head.
- inst_code  out  32  encoded word at FIFO head.
- out_err  out  1  head word came from an unencodable record.
- enc_count  out  CNT_W  words pushed into the FIFO; wraps.
- err_count  out  8  unencodable records; saturates at 255.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - s1 stage emptied; FIFO pointers and occupancy cleared.
  - out_valid=0, inst_code=0, out_err=0, enc_count=0, err_count=0.
  - in_ready=0 during the reset cycle and 1 from the first cycle after.
  - Reset mid-stream discards all buffered words and the s1 record.
- Accept: a record is accepted at a rising edge when in_valid & in_ready. Field values are ignored when not accepted.
- in_ready = (occupancy + s1_valid) < DEPTH. It depends only on registered state, with no combinational path from out_ready.
- Stage s1: the accepted record is registered. In the next cycle it is encoded combinationally and pushed into the FIFO at the following edge. s1 never stalls.
- Latency: record accepted at edge N → out_valid=1 after edge N+1 if the FIFO was empty. Throughput is 1 word/cycle while out_ready=1.
- Encoding:
  - R-type: {6'b0, rs, rt, rd, shamt, funct}.
    - funct: SLL 00, SRL 02, SRA 03, JR 08, ADDU 21, SUBU 23, AND 24, OR 25, XOR 26, NOR 27, SLT 2A, SLTU 2B (hex).
    - shamt is forced to 0 for all but SLL/SRL/SRA.
    - JR forces rt=rd=0.
  - I-type: {op, rs, rt, imm}.
    - op: BEQ 04, BNE 05, ADDIU 09, SLTI 0A, ANDI 0C, ORI 0D, XORI 0E, LUI 0F, LW 23, SW 2B (hex).
    - LUI forces rs=0.
  - J-type: {op, jump_addr}, with J op=02 and JAL op=03.
- Unencodable: inst_type INVALID, or the inst not in the list for its inst_type.
  - Pushes word 0x00000000 with err=1.
  - err_count increments, saturating at 255.
- enc_count increments on every FIFO push, including error words, and wraps at 2^CNT_W.
- FIFO:
  - Stores {err, word}.
  - Pop when out_valid & out_ready.
  - Simultaneous push and pop leave occupancy unchanged; this is legal even when occupancy=DEPTH.
  - Pointers wrap modulo DEPTH.
  - inst_code and out_err are 0 while out_valid=0.
- Overflow cannot occur. The in_ready rule reserves a slot for the s1 record.
- out_ready held 0: at most DEPTH records are accepted in total, after which in_ready=0. No word is lost or duplicated.

Test Plan:
- ADDU rs=1 rt=2 rd=3 → inst_code=0x00221821, out_err=0, out_valid one cycle after the accept edge; enc_count=1.
- SLL rt=2 rd=4 shift=5 → 0x00022140. JR rs=31 with rt=7, rd=7 supplied → 0x03E00008.
- ADDIU rs=0 rt=8 imm=0xFFFF → 0x2408FFFF. LUI rs=5 rt=1 imm=0x1234 → 0x3C011234. JAL jump_addr=0x0100000 → 0x0C100000.
- inst_type=INVALID, then `INST_TYPE_R` with inst=ADDIU → two words 0x00000000 with out_err=1; err_count=2; following valid record encodes normally.
- out_ready=0, in_valid held 1 → exactly DEPTH (4) accepts, then in_ready=0. Set out_ready=1 → 4 words drained in order, 1/cycle; concurrent push/pop at full sustains throughput.
- Assert rst_n=0 with 3 words buffered → next cycle out_valid=0, counters 0, in_ready=1; no stale word emerges afterwards.
